// File: rtl/regfile_param.sv
// rtl/regfile_param.sv - parametrised register file with bulk-clear engine and snoop channel
//
// Purpose: DEPTH = 2**ADDR_W registers of DATA_W bits for the game CPU.
//          It has two combinational read ports and one rising-edge write port
//          with an optional write-to-read bypass. A two-state engine clears
//          every register, one per cycle. A valid/ready channel flags changes
//          to the block-ID register (SNOOP_REG).
// Ports:
//   clock, ctrl_reset            clock; asynchronous active-low reset
//   ctrl_writeEnable/_writeReg   write request and address
//   data_writeReg                write data
//   ctrl_readRegA/B              read addresses
//   data_readRegA/B              read data (combinational)
//   clear_req / clear_busy       start bulk clear / clear in progress
//   snoop_data/_valid/_ready     block-ID mirror and its change handshake
module regfile_param #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 5,
  parameter int ZERO_REG  = 1,
  parameter int BYPASS    = 1,
  parameter int SNOOP_REG = 29
) (
  input  logic              clock,
  input  logic              ctrl_reset,
  input  logic              ctrl_writeEnable,
  input  logic [ADDR_W-1:0] ctrl_writeReg,
  input  logic [DATA_W-1:0] data_writeReg,
  input  logic [ADDR_W-1:0] ctrl_readRegA,
  input  logic [ADDR_W-1:0] ctrl_readRegB,
  output logic [DATA_W-1:0] data_readRegA,
  output logic [DATA_W-1:0] data_readRegB,
  input  logic              clear_req,
  output logic              clear_busy,
  output logic [DATA_W-1:0] snoop_data,
  output logic              snoop_valid,
  input  logic              snoop_ready
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] SNOOP_ADDR = ADDR_W'(SNOOP_REG);
  localparam logic [ADDR_W-1:0] LAST_IDX   = ADDR_W'(DEPTH - 1);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t            state, state_next;
  logic [ADDR_W-1:0] idx;
  logic [DATA_W-1:0] regs [DEPTH];
  logic              wr_ok;
  logic              snoop_set;

  assign clear_busy = (state == CLEAR);

  // Register 0 is hard-wired when ZERO_REG is set, so writes to it never count.
  assign wr_ok = ctrl_writeEnable && !clear_busy &&
                 !((ZERO_REG != 0) && (ctrl_writeReg == '0));

  // A clear step on the snoop index changes its contents too, so it flags an event.
  assign snoop_set = (wr_ok && (ctrl_writeReg == SNOOP_ADDR)) ||
                     (clear_busy && (idx == SNOOP_ADDR));

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (clear_req) state_next = CLEAR;
      CLEAR:   if (idx == LAST_IDX) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge ctrl_reset) begin
    if (!ctrl_reset) begin
      state <= IDLE;
      idx   <= '0;
    end else begin
      state <= state_next;
      // idx restarts at 0 when the clear ends, so it never wraps past DEPTH-1.
      if (state == CLEAR && idx != LAST_IDX) idx <= idx + 1'b1;
      else                                   idx <= '0;
    end
  end

  always_ff @(posedge clock or negedge ctrl_reset) begin
    if (!ctrl_reset) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else if (clear_busy) begin
      regs[idx] <= '0;
    end else if (wr_ok) begin
      regs[ctrl_writeReg] <= data_writeReg;
    end
  end

  // A set event on the same edge as a handshake wins, so no update is lost.
  always_ff @(posedge clock or negedge ctrl_reset) begin
    if (!ctrl_reset)                    snoop_valid <= 1'b0;
    else if (snoop_set)                 snoop_valid <= 1'b1;
    else if (snoop_valid && snoop_ready) snoop_valid <= 1'b0;
  end

  always_comb begin
    data_readRegA = regs[ctrl_readRegA];
    if ((ZERO_REG != 0) && (ctrl_readRegA == '0)) data_readRegA = '0;
    if ((BYPASS != 0) && wr_ok && (ctrl_writeReg == ctrl_readRegA)) data_readRegA = data_writeReg;
  end

  always_comb begin
    data_readRegB = regs[ctrl_readRegB];
    if ((ZERO_REG != 0) && (ctrl_readRegB == '0)) data_readRegB = '0;
    if ((BYPASS != 0) && wr_ok && (ctrl_writeReg == ctrl_readRegB)) data_readRegB = data_writeReg;
  end

  always_comb begin
    snoop_data = regs[SNOOP_ADDR];
    if ((ZERO_REG != 0) && (SNOOP_ADDR == '0)) snoop_data = '0;
  end

endmodule

// File: tb/tb_regfile_param.sv
// tb/tb_regfile_param.sv - directed scoreboard bench for regfile_param
module tb_regfile_param;

  logic        clock = 1'b0;
  logic        ctrl_reset;
  logic        we;
  logic [4:0]  wr;
  logic [31:0] wdata;
  logic [4:0]  ra, rb;
  logic [31:0] rda, rdb;
  logic        clear_req, clear_busy;
  logic [31:0] sdata;
  logic        svalid, sready;

  logic [31:0] nb_rda, nb_rdb, nb_sdata;
  logic        nb_busy, nb_svalid;

  int pass_cnt = 0;
  int total_cnt = 0;
  logic [31:0] exp_q [$];
  int cnt;

  always #5 clock = ~clock;

  regfile_param dut (
    .clock(clock), .ctrl_reset(ctrl_reset),
    .ctrl_writeEnable(we), .ctrl_writeReg(wr), .data_writeReg(wdata),
    .ctrl_readRegA(ra), .ctrl_readRegB(rb),
    .data_readRegA(rda), .data_readRegB(rdb),
    .clear_req(clear_req), .clear_busy(clear_busy),
    .snoop_data(sdata), .snoop_valid(svalid), .snoop_ready(sready)
  );

  regfile_param #(.BYPASS(0)) dut_nb (
    .clock(clock), .ctrl_reset(ctrl_reset),
    .ctrl_writeEnable(we), .ctrl_writeReg(wr), .data_writeReg(wdata),
    .ctrl_readRegA(ra), .ctrl_readRegB(rb),
    .data_readRegA(nb_rda), .data_readRegB(nb_rdb),
    .clear_req(clear_req), .clear_busy(nb_busy),
    .snoop_data(nb_sdata), .snoop_valid(nb_svalid), .snoop_ready(sready)
  );

  task automatic exp_push(input logic [31:0] v);
    exp_q.push_back(v);
  endtask

  task automatic check(input string tag, input logic [31:0] actual);
    logic [31:0] e;
    total_cnt++;
    if (exp_q.size() == 0) begin
      $error("FAIL %s: got %h, no expected value queued", tag, actual);
    end else begin
      e = exp_q.pop_front();
      assert (actual === e) pass_cnt++;
      else $error("FAIL %s: got %h, expected %h", tag, actual, e);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    ctrl_reset = 1'b0; we = 0; wr = 0; wdata = 0; ra = 0; rb = 0;
    clear_req = 0; sready = 0;
    #12;
    exp_push(0); check("rst_rda", rda);
    exp_push(0); check("rst_busy", {31'd0, clear_busy});
    exp_push(0); check("rst_svalid", {31'd0, svalid});
    exp_push(0); check("rst_sdata", sdata);
    exp_push(0); check("rst_nb", nb_rda | nb_rdb | nb_sdata | {30'd0, nb_busy, nb_svalid});
    tick();
    ctrl_reset = 1'b1;

    // basic write, latency 1, r0 reads 0
    we = 1; wr = 5; wdata = 32'hDEADBEEF; ra = 0; rb = 0;
    tick();
    we = 0; ra = 5; rb = 0; #1;
    exp_push(32'hDEADBEEF); check("wr_r5_a", rda);
    exp_push(0); check("rd_r0_b", rdb);

    // bypass vs no bypass
    we = 1; wr = 7; wdata = 32'h12345678; ra = 7; #1;
    exp_push(32'h12345678); check("bypass_a", rda);
    exp_push(0); check("nobypass_a", nb_rda);
    tick();
    we = 0; #1;
    exp_push(32'h12345678); check("nobypass_next", nb_rda);

    // writes to r0 ignored, no bypass for them
    we = 1; wr = 0; wdata = 32'hFFFFFFFF; ra = 0; #1;
    exp_push(0); check("r0_bypass", rda);
    tick();
    we = 0; #1;
    exp_push(0); check("r0_read", rda);
    exp_push(0); check("r0_svalid", {31'd0, svalid});

    // snoop channel
    sready = 0; we = 1; wr = 29; wdata = 32'h4;
    tick();
    we = 0; #1;
    exp_push(1); check("snoop_set", {31'd0, svalid});
    exp_push(4); check("snoop_data4", sdata);
    we = 1; wr = 29; wdata = 32'h9;
    tick();
    we = 0; #1;
    exp_push(1); check("snoop_coalesce", {31'd0, svalid});
    exp_push(9); check("snoop_data9", sdata);
    sready = 1; we = 1; wr = 29; wdata = 32'h11;
    tick();
    we = 0; #1;
    exp_push(1); check("snoop_set_wins", {31'd0, svalid});
    exp_push(32'h11); check("snoop_data11", sdata);
    tick();
    #1;
    exp_push(0); check("snoop_ack", {31'd0, svalid});
    sready = 0;

    // fill r1..r31
    for (int i = 1; i < 32; i++) begin
      we = 1; wr = 5'(i); wdata = 32'hA000_0000 | 32'(i);
      tick();
    end
    we = 0; ra = 1; rb = 31; #1;
    exp_push(32'hA000_0001); check("fill_r1", rda);
    exp_push(32'hA000_001F); check("fill_r31", rdb);
    sready = 1;
    tick();
    sready = 0; #1;
    exp_push(0); check("fill_ack", {31'd0, svalid});

    // bulk clear
    clear_req = 1;
    tick();
    clear_req = 0;
    cnt = 0;
    while (clear_busy && cnt < 100) begin
      if (cnt == 10) begin
        we = 1; wr = 3; wdata = 32'h5555AAAA; ra = 3; #1;
        exp_push(0); check("clr_no_bypass", rda);
      end else begin
        we = 0;
      end
      tick();
      cnt++;
    end
    we = 0;
    exp_push(32); check("clr_busy_cycles", 32'(cnt));
    exp_push(1); check("clr_snoop_valid", {31'd0, svalid});
    exp_push(0); check("clr_snoop_data", sdata);
    for (int i = 0; i < 32; i++) begin
      ra = 5'(i); #1;
      exp_push(0); check($sformatf("clr_r%0d", i), rda);
    end
    sready = 1;
    tick();
    sready = 0;

    // reset mid-clear
    we = 1; wr = 20; wdata = 32'h55;
    tick();
    we = 0; clear_req = 1;
    tick();
    clear_req = 0;
    repeat (10) tick();
    ra = 20; #1;
    exp_push(32'h55); check("midclr_r20", rda);
    exp_push(1); check("midclr_busy", {31'd0, clear_busy});
    #2 ctrl_reset = 0;
    #1;
    exp_push(0); check("arst_busy", {31'd0, clear_busy});
    exp_push(0); check("arst_r20", rda);
    exp_push(0); check("arst_svalid", {31'd0, svalid});
    tick();
    ctrl_reset = 1;
    we = 1; wr = 20; wdata = 32'h77; rb = 20;
    tick();
    we = 0; #1;
    exp_push(0); check("post_rst_busy", {31'd0, clear_busy});
    exp_push(32'h77); check("post_rst_wr", rdb);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
